// File: rtl/sift_ori_hist_pkg.sv
// Shared types and constants for the SIFT orientation histogram block.
// The state encoding is fixed because other stages decode it directly.
package sift_ori_hist_pkg;

   localparam int NBINS = 32;
   localparam int DIR_W = 5;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SCAN  = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // All-ones value of a w-bit unsigned accumulator; used as the saturation ceiling.
   function automatic logic [31:0] acc_max(input int unsigned w);
      if (w >= 32'd32) begin
         return 32'hffff_ffff;
      end else begin
         return (32'd1 << w) - 32'd1;
      end
   endfunction

endpackage

// File: rtl/sift_hist_argmax.sv
// Sequential running-maximum tracker with lowest-index tie-break.
// best_val/best_idx already include the sample presented this cycle.
module sift_hist_argmax #(
   parameter int VAL_W = 16,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             first,
   input  logic [IDX_W-1:0] idx,
   input  logic [VAL_W-1:0] val,
   output logic [VAL_W-1:0] best_val,
   output logic [IDX_W-1:0] best_idx
);

   logic [VAL_W-1:0] max_q, max_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // Strictly-greater replacement keeps the earliest index on ties; first restarts the search.
   always_comb begin
      max_d = max_q;
      idx_d = idx_q;
      if (en && (first || (val > max_q))) begin
         max_d = val;
         idx_d = idx;
      end else begin
         max_d = max_q;
         idx_d = idx_q;
      end
   end

   // Running-max state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q <= {VAL_W{1'b0}};
         idx_q <= {IDX_W{1'b0}};
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
      end
   end

   assign best_val = max_d;
   assign best_idx = idx_d;

endmodule

// File: rtl/sift_ori_hist.sv
// 32-bin orientation histogram over one keypoint window: saturating accumulate,
// then a 32-cycle scan that finds the dominant bin and clears the histogram.
module sift_ori_hist
   import sift_ori_hist_pkg::*;
#(
   parameter int MAG_W = 8,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [4:0]       s_dir,
   input  logic [MAG_W-1:0] s_mag,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [4:0]       m_bin,
   output logic [ACC_W-1:0] m_peak,
   output logic             m_empty
);

   localparam logic [ACC_W-1:0] ACC_MAX   = ACC_W'(acc_max(ACC_W));
   localparam logic [DIR_W-1:0] SCAN_LAST = DIR_W'(NBINS - 1);

   state_e           state_q, state_d;
   logic [DIR_W-1:0] scan_idx_q, scan_idx_d;
   logic [ACC_W-1:0] bins_q [NBINS];
   logic [ACC_W-1:0] bins_d [NBINS];
   logic             s_ready_q, s_ready_d;
   logic             m_valid_q, m_valid_d;
   logic [DIR_W-1:0] m_bin_q, m_bin_d;
   logic [ACC_W-1:0] m_peak_q, m_peak_d;
   logic             m_empty_q, m_empty_d;

   logic [ACC_W:0]   sum_s;
   logic [ACC_W-1:0] sat_s;
   logic [ACC_W-1:0] best_val_s;
   logic [DIR_W-1:0] best_idx_s;
   logic             scanning_s;

   // Carry out of the widened add flags overflow; clamp rather than wrap.
   always_comb begin
      sum_s = {1'b0, bins_q[s_dir]} + (ACC_W + 1)'(s_mag);
      if (sum_s[ACC_W]) begin
         sat_s = ACC_MAX;
      end else begin
         sat_s = sum_s[ACC_W-1:0];
      end
   end

   assign scanning_s = (state_q == ST_SCAN);

   sift_hist_argmax #(
      .VAL_W (ACC_W),
      .IDX_W (DIR_W)
   ) u_argmax (
      .clk      (clk),
      .rst      (rst),
      .en       (scanning_s),
      .first    (scan_idx_q == {DIR_W{1'b0}}),
      .idx      (scan_idx_q),
      .val      (bins_q[scan_idx_q]),
      .best_val (best_val_s),
      .best_idx (best_idx_s)
   );

   // Next-state and datapath control for accumulate / scan / hold.
   always_comb begin
      state_d    = state_q;
      scan_idx_d = scan_idx_q;
      bins_d     = bins_q;
      s_ready_d  = s_ready_q;
      m_valid_d  = m_valid_q;
      m_bin_d    = m_bin_q;
      m_peak_d   = m_peak_q;
      m_empty_d  = m_empty_q;
      case (state_q)
         ST_ACCUM: begin
            s_ready_d = 1'b1;
            if (s_valid && s_ready_q) begin
               bins_d[s_dir] = sat_s;
               if (s_last) begin
                  state_d    = ST_SCAN;
                  s_ready_d  = 1'b0;
                  scan_idx_d = {DIR_W{1'b0}};
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_SCAN: begin
            s_ready_d          = 1'b0;
            bins_d[scan_idx_q] = {ACC_W{1'b0}};
            if (scan_idx_q == SCAN_LAST) begin
               m_bin_d    = best_idx_s;
               m_peak_d   = best_val_s;
               m_empty_d  = (best_val_s == {ACC_W{1'b0}});
               m_valid_d  = 1'b1;
               state_d    = ST_HOLD;
               scan_idx_d = {DIR_W{1'b0}};
            end else begin
               scan_idx_d = scan_idx_q + 5'd1;
            end
         end
         ST_HOLD: begin
            if (m_valid_q && m_ready) begin
               m_valid_d = 1'b0;
               s_ready_d = 1'b1;
               state_d   = ST_ACCUM;
            end else begin
               s_ready_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_ACCUM;
            s_ready_d  = 1'b1;
            m_valid_d  = 1'b0;
            scan_idx_d = {DIR_W{1'b0}};
         end
      endcase
   end

   // State, histogram and output registers; reset drops any pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ACCUM;
         scan_idx_q <= {DIR_W{1'b0}};
         for (int i = 0; i < NBINS; i++) begin
            bins_q[i] <= {ACC_W{1'b0}};
         end
         s_ready_q  <= 1'b1;
         m_valid_q  <= 1'b0;
         m_bin_q    <= {DIR_W{1'b0}};
         m_peak_q   <= {ACC_W{1'b0}};
         m_empty_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         scan_idx_q <= scan_idx_d;
         bins_q     <= bins_d;
         s_ready_q  <= s_ready_d;
         m_valid_q  <= m_valid_d;
         m_bin_q    <= m_bin_d;
         m_peak_q   <= m_peak_d;
         m_empty_q  <= m_empty_d;
      end
   end

   assign s_ready = s_ready_q;
   assign m_valid = m_valid_q;
   assign m_bin   = m_bin_q;
   assign m_peak  = m_peak_q;
   assign m_empty = m_empty_q;

endmodule

// File: tb/tb_sift_ori_hist.sv
// Scoreboard bench for sift_ori_hist: a histogram model predicts each window's
// dominant bin; a monitor checks results, hold stability, handshake and latency.
module tb_sift_ori_hist;

   localparam int MAG_W = 8;
   localparam int ACC_W = 16;
   localparam int SAT   = 65535;

   typedef struct {
      int bin;
      int peak;
      int empty;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [4:0]       s_dir;
   logic [MAG_W-1:0] s_mag;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [4:0]       m_bin;
   logic [ACC_W-1:0] m_peak;
   logic             m_empty;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   hold_cycles = 0;
   int   hist [32];
   exp_t exp_q [$];

   sift_ori_hist #(.MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_dir   (s_dir),
      .s_mag   (s_mag),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_bin   (m_bin),
      .m_peak  (m_peak),
      .m_empty (m_empty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_now();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   // Reference: dominant bin is the first index holding the largest count.
   function automatic exp_t predict();
      exp_t e;
      e.bin  = 0;
      e.peak = 0;
      for (int i = 0; i < 32; i++) begin
         if (hist[i] > e.peak) begin
            e.peak = hist[i];
            e.bin  = i;
         end
      end
      e.empty = (e.peak == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < 32; i++) hist[i] = 0;
   endtask

   task automatic send(input int d, input int m, input int l);
      int guard;
      guard = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_dir   = 5'(d);
      s_mag   = 8'(m);
      s_last  = l[0];
      while (!s_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 5000) begin
            chk("s_ready_timeout", 0, 1);
            finish_now();
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      hist[d & 31] = (hist[d & 31] + m > SAT) ? SAT : hist[d & 31] + m;
      if (l != 0) begin
         exp_q.push_back(predict());
         clear_hist();
         acc_cyc = cyc;
      end
   endtask

   // Downstream: stalls each result for hold_cycles cycles before accepting.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      m_ready  = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (m_valid) begin
            if (wait_cnt >= hold_cycles) begin
               m_ready = 1'b1;
            end else begin
               m_ready = 1'b0;
               wait_cnt++;
            end
         end else begin
            m_ready  = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Monitor: pops expectations when a result appears and checks it every valid cycle.
   initial begin
      exp_t cur;
      bit   prev_v;
      bit   post_hs;
      prev_v  = 1'b0;
      post_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v  = 1'b0;
            post_hs = 1'b0;
         end else begin
            if (post_hs) begin
               chk("s_ready_after_handshake", int'(s_ready), 1);
               chk("m_valid_drop_after_handshake", int'(m_valid), 0);
               post_hs = 1'b0;
            end
            if (m_valid) begin
               if (!prev_v) begin
                  chk("result_latency", cyc - acc_cyc, 32);
                  if (exp_q.size() == 0) begin
                     chk("unexpected_result", 1, 0);
                     cur.bin = -1; cur.peak = -1; cur.empty = -1;
                  end else begin
                     cur = exp_q.pop_front();
                  end
               end
               chk("m_bin", int'(m_bin), cur.bin);
               chk("m_peak", int'(m_peak), cur.peak);
               chk("m_empty", int'(m_empty), cur.empty);
               chk("s_ready_low_while_result", int'(s_ready), 0);
               if (m_ready) post_hs = 1'b1;
            end
            prev_v = m_valid;
         end
      end
   end

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 || m_valid || !s_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            chk("drain_timeout", 0, 1);
            finish_now();
         end
      end
   endtask

   initial begin
      int n;
      int mode;
      clear_hist();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_dir   = 5'd0;
      s_mag   = 8'd0;
      s_last  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_s_ready", int'(s_ready), 1);
      chk("reset_m_valid", int'(m_valid), 0);
      chk("reset_m_bin", int'(m_bin), 0);
      chk("reset_m_peak", int'(m_peak), 0);
      chk("reset_m_empty", int'(m_empty), 0);
      rst = 1'b0;

      // Basic window: bin 5 collects 30, bin 7 collects 25.
      repeat (3) send(5, 10, 0);
      send(7, 25, 1);
      wait_drain();

      // Wrap and tie: 5'h1f lands in bin 31, tie resolves to bin 2.
      send(31, 40, 0);
      send(2, 40, 1);
      wait_drain();

      // Saturation of a single bin.
      for (int i = 0; i < 300; i++) send(0, 255, (i == 299) ? 1 : 0);
      wait_drain();

      // Back-pressure, then a fresh window that must not see old data.
      hold_cycles = 10;
      send(9, 200, 0);
      send(9, 100, 1);
      wait_drain();
      hold_cycles = 0;
      send(4, 1, 1);
      wait_drain();

      // All-zero window.
      for (int i = 0; i < 4; i++) send(i * 7, 0, (i == 3) ? 1 : 0);
      wait_drain();

      // Reset at scan index 10 drops the pending result.
      send(12, 77, 0);
      send(20, 50, 1);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      void'(exp_q.pop_back());
      clear_hist();
      @(negedge clk);
      chk("midscan_reset_s_ready", int'(s_ready), 1);
      chk("midscan_reset_m_valid", int'(m_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      send(3, 9, 1);
      wait_drain();

      // Randomised windows with gaps, small-value ties and random stalls.
      for (int w = 0; w < 16; w++) begin
         n    = $urandom_range(1, 24);
         mode = $urandom_range(0, 2);
         hold_cycles = $urandom_range(0, 4);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            if (mode == 0) send($urandom_range(0, 31), $urandom_range(0, 255), (k == n - 1) ? 1 : 0);
            else if (mode == 1) send($urandom_range(0, 7), 5 * $urandom_range(0, 2), (k == n - 1) ? 1 : 0);
            else send($urandom_range(0, 3), 255 - $urandom_range(0, 3), (k == n - 1) ? 1 : 0);
         end
         wait_drain();
      end

      hold_cycles = 0;
      repeat (5) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      finish_now();
   end

   initial begin
      #2000000;
      chk("global_timeout", 0, 1);
      finish_now();
   end

endmodule
